// File: rtl/sync_fifo_ctrl_if.sv
// Handshake and status bundle between a FIFO user and sync_fifo_ctrl.
// Optional SYNC_FIFO_ERR_EN adds sticky overflow/underflow flags.
interface sync_fifo_ctrl_if #(
  parameter int FIFO_PTR = 4
);
  logic                push;
  logic                pop;
  logic                wren;
  logic                rden;
  logic [FIFO_PTR-1:0] wrptr;
  logic [FIFO_PTR-1:0] rdptr;
  logic                rd_valid;
  logic                full;
  logic                empty;
  logic                almost_full;
  logic                almost_empty;
  logic [FIFO_PTR:0]   count;
`ifdef SYNC_FIFO_ERR_EN
  logic                overflow;
  logic                underflow;

  modport master (
    output push, pop,
    input  wren, rden, wrptr, rdptr,
    input  rd_valid, full, empty,
    input  almost_full, almost_empty, count,
    input  overflow, underflow
  );

  modport slave (
    input  push, pop,
    output wren, rden, wrptr, rdptr,
    output rd_valid, full, empty,
    output almost_full, almost_empty, count,
    output overflow, underflow
  );
`else
  modport master (
    output push, pop,
    input  wren, rden, wrptr, rdptr,
    input  rd_valid, full, empty,
    input  almost_full, almost_empty, count
  );

  modport slave (
    input  push, pop,
    output wren, rden, wrptr, rdptr,
    output rd_valid, full, empty,
    output almost_full, almost_empty, count
  );
`endif
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Pointer/status controller driving a dual-port sram as a synchronous FIFO.
// Define SYNC_FIFO_ERR_EN for sticky overflow/underflow flags.
module sync_fifo_ctrl #(
  parameter int FIFO_PTR   = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4
) (
  input logic clk,
  input logic rst,
  sync_fifo_ctrl_if.slave bus
);
  localparam int PW = FIFO_PTR + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] cnt;
  logic          rv;
  logic          wr_acc;
  logic          rd_acc;
  logic          full_q;
  logic          empty_q;

  assign full_q  = (cnt == PW'(FIFO_DEPTH));
  assign empty_q = (cnt == '0);

  // rst gates sram strobes so a reset mid-stream never touches memory
  assign wr_acc = bus.push & ~full_q & ~rst;
  assign rd_acc = bus.pop & ~empty_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rv     <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      rv <= rd_acc;
    end
  end

  assign bus.wren         = wr_acc;
  assign bus.rden         = rd_acc;
  assign bus.wrptr        = wr_ptr[FIFO_PTR-1:0];
  assign bus.rdptr        = rd_ptr[FIFO_PTR-1:0];
  assign bus.rd_valid     = rv;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = (cnt >= PW'(AF_LEVEL));
  assign bus.almost_empty = (cnt <= PW'(AE_LEVEL));
  assign bus.count        = cnt;

`ifdef SYNC_FIFO_ERR_EN
  logic ovf;
  logic unf;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (bus.push & full_q)  ovf <= 1'b1;
      if (bus.pop  & empty_q) unf <= 1'b1;
    end
  end

  assign bus.overflow  = ovf;
  assign bus.underflow = unf;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl with a behavioural sram.
// Honours SYNC_FIFO_ERR_EN when defined.
module tb_sync_fifo_ctrl;
  localparam int P = 4;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.FIFO_PTR(P)) bus ();

  sync_fifo_ctrl #(
    .FIFO_PTR(P), .FIFO_DEPTH(D),
    .AF_LEVEL(12), .AE_LEVEL(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [15:0] mem [D];
  logic [15:0] wrdata = '0;
  logic [15:0] rddata;

  always @(posedge clk) begin
    if (bus.wren) mem[bus.wrptr] <= wrdata;
    if (bus.rden) rddata <= mem[bus.rdptr];
  end

  int total = 0;
  int bad = 0;

  int  m_count = 0;
  int  m_wr = 0;
  int  m_rd = 0;
  logic m_rv = 1'b0;
  logic cur_rst = 1'b1;
  logic cur_push = 1'b0;
  logic cur_pop = 1'b0;
  logic mon_en = 1'b0;
  logic [15:0] sb [$];

  task automatic drive(input logic r, p, q,
                       input logic [15:0] d);
    cur_rst = r;
    cur_push = p;
    cur_pop = q;
    rst = r;
    bus.push = p;
    bus.pop = q;
    wrdata = d;
    #1;
  endtask

  task automatic step();
    logic wa, ra;
    wa = cur_push & (m_count != D) & ~cur_rst;
    ra = cur_pop & (m_count != 0) & ~cur_rst;
    @(posedge clk);
    if (cur_rst) begin
      m_count = 0;
      m_wr = 0;
      m_rd = 0;
      m_rv = 1'b0;
      sb.delete();
    end else begin
      if (wa) begin
        sb.push_back(wrdata);
        m_wr = (m_wr + 1) % 32;
      end
      if (ra) m_rd = (m_rd + 1) % 32;
      m_count = m_count + int'(wa) - int'(ra);
      m_rv = ra;
    end
    #1;
  endtask

  // Per-cycle monitor: strobes, count, read data and invariants
  always @(negedge clk) begin
    if (mon_en) begin
      logic ew, er;
      logic [15:0] ed;
      logic [4:0] df;
      logic fi;
      ew = cur_push & (m_count != D) & ~cur_rst;
      er = cur_pop & (m_count != 0) & ~cur_rst;
      total++;
      if (bus.wren !== ew) begin
        bad++;
        $display("FAIL mon_wren got=%b exp=%b", bus.wren, ew);
      end
      total++;
      if (bus.rden !== er) begin
        bad++;
        $display("FAIL mon_rden got=%b exp=%b", bus.rden, er);
      end
      total++;
      if (bus.count !== 5'(m_count)) begin
        bad++;
        $display("FAIL mon_count got=%0d exp=%0d",
                 bus.count, m_count);
      end
      total++;
      if (bus.rd_valid !== m_rv) begin
        bad++;
        $display("FAIL mon_rd_valid got=%b exp=%b",
                 bus.rd_valid, m_rv);
      end
      if (m_rv) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL mon_sb_empty got=read exp=none");
        end else begin
          ed = sb.pop_front();
          if (rddata !== ed) begin
            bad++;
            $display("FAIL mon_rddata got=%h exp=%h", rddata, ed);
          end
        end
      end
      df = dut.wr_ptr - dut.rd_ptr;
      total++;
      if (bus.count !== df) begin
        bad++;
        $display("FAIL inv_count got=%0d exp=%0d", bus.count, df);
      end
      fi = (dut.wr_ptr[3:0] == dut.rd_ptr[3:0]) &&
           (dut.wr_ptr[4] != dut.rd_ptr[4]);
      total++;
      if (bus.full !== fi) begin
        bad++;
        $display("FAIL inv_full got=%b exp=%b", bus.full, fi);
      end
    end
  end

  task automatic test_reset();
    drive(1, 0, 0, 16'h0);
    step();
    step();
    mon_en = 1'b1;
    drive(0, 0, 0, 16'h0);
    repeat (3) step();
    total++;
    if ({bus.count, bus.empty, bus.almost_empty, bus.full,
         bus.almost_full, bus.wren, bus.rden, bus.rd_valid}
        !== {5'd0, 7'b1100000}) begin
      bad++;
      $display("FAIL reset got=%0d/%b%b%b%b%b%b%b exp=0/1100000",
               bus.count, bus.empty, bus.almost_empty, bus.full,
               bus.almost_full, bus.wren, bus.rden, bus.rd_valid);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < D; i++) begin
      drive(0, 1, 0, 16'(16'h100 + i));
      total++;
      if (bus.wrptr !== 4'(i)) begin
        bad++;
        $display("FAIL fill_wrptr got=%0d exp=%0d", bus.wrptr, i);
      end
      step();
      if (i == 3 || i == 4) begin
        total++;
        if (bus.almost_empty !== (i == 3)) begin
          bad++;
          $display("FAIL fill_ae n=%0d got=%b", i + 1,
                   bus.almost_empty);
        end
      end
      if (i == 10 || i == 11) begin
        total++;
        if (bus.almost_full !== (i == 11)) begin
          bad++;
          $display("FAIL fill_af n=%0d got=%b", i + 1,
                   bus.almost_full);
        end
      end
    end
    total++;
    if ({bus.full, bus.count, bus.wrptr} !== {1'b1, 5'd16, 4'd0}) begin
      bad++;
      $display("FAIL fill_full got=%b/%0d/%0d exp=1/16/0",
               bus.full, bus.count, bus.wrptr);
    end
    drive(0, 1, 0, 16'h1FF);
    total++;
    if (bus.wren !== 1'b0) begin
      bad++;
      $display("FAIL over_wren got=%b exp=0", bus.wren);
    end
    step();
    total++;
    if (bus.count !== 5'd16) begin
      bad++;
      $display("FAIL over_count got=%0d exp=16", bus.count);
    end
`ifdef SYNC_FIFO_ERR_EN
    total++;
    if (bus.overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow got=%b exp=1", bus.overflow);
    end
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < D; i++) begin
      drive(0, 0, 1, 16'h0);
      step();
      total++;
      if (bus.rd_valid !== 1'b1 || rddata !== 16'(16'h100 + i)) begin
        bad++;
        $display("FAIL drain_data i=%0d got=%b/%h exp=1/%h", i,
                 bus.rd_valid, rddata, 16'(16'h100 + i));
      end
    end
    total++;
    if (bus.empty !== 1'b1) begin
      bad++;
      $display("FAIL drain_empty got=%b exp=1", bus.empty);
    end
    drive(0, 0, 1, 16'h0);
    total++;
    if (bus.rden !== 1'b0) begin
      bad++;
      $display("FAIL under_rden got=%b exp=0", bus.rden);
    end
    step();
    total++;
    if (bus.rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL under_rv got=%b exp=0", bus.rd_valid);
    end
`ifdef SYNC_FIFO_ERR_EN
    total++;
    if (bus.underflow !== 1'b1) begin
      bad++;
      $display("FAIL underflow got=%b exp=1", bus.underflow);
    end
`endif
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 16'(16'h200 + i));
      step();
    end
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 1, 16'(16'h300 + i));
      step();
      total++;
      if (bus.count !== 5'd8) begin
        bad++;
        $display("FAIL stream_count i=%0d got=%0d exp=8", i,
                 bus.count);
      end
    end
    total++;
    if ({bus.wrptr, bus.rdptr} !== {4'd12, 4'd4}) begin
      bad++;
      $display("FAIL stream_ptrs got=%0d/%0d exp=12/4",
               bus.wrptr, bus.rdptr);
    end
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 1, 16'h0);
      step();
    end
  endtask

  task automatic test_simul();
    for (int i = 0; i < D; i++) begin
      drive(0, 1, 0, 16'(16'h400 + i));
      step();
    end
    drive(0, 1, 1, 16'h4FF);
    total++;
    if ({bus.wren, bus.rden} !== 2'b01) begin
      bad++;
      $display("FAIL sim_full_en got=%b%b exp=01", bus.wren, bus.rden);
    end
    step();
    total++;
    if (bus.count !== 5'd15) begin
      bad++;
      $display("FAIL sim_full_count got=%0d exp=15", bus.count);
    end
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 16'h0);
      step();
    end
    drive(0, 1, 1, 16'h4AA);
    total++;
    if ({bus.wren, bus.rden} !== 2'b10) begin
      bad++;
      $display("FAIL sim_empty_en got=%b%b exp=10", bus.wren, bus.rden);
    end
    step();
    total++;
    if (bus.count !== 5'd1 || bus.rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL sim_empty got=%0d/%b exp=1/0", bus.count,
               bus.rd_valid);
    end
    drive(0, 0, 1, 16'h0);
    step();
    drive(0, 0, 0, 16'h0);
    step();
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 16'(16'h500 + i));
      step();
    end
    drive(1, 1, 1, 16'h5FF);
    total++;
    if ({bus.wren, bus.rden} !== 2'b00) begin
      bad++;
      $display("FAIL mrst_en got=%b%b exp=00", bus.wren, bus.rden);
    end
    step();
    total++;
    if ({bus.count, bus.empty, bus.rd_valid} !== {5'd0, 2'b10}) begin
      bad++;
      $display("FAIL mrst_state got=%0d/%b/%b exp=0/1/0",
               bus.count, bus.empty, bus.rd_valid);
    end
`ifdef SYNC_FIFO_ERR_EN
    total++;
    if ({bus.overflow, bus.underflow} !== 2'b00) begin
      bad++;
      $display("FAIL mrst_err got=%b%b exp=00", bus.overflow,
               bus.underflow);
    end
`endif
    drive(0, 0, 0, 16'h0);
    step();
  endtask

  initial begin
    bus.push = 1'b0;
    bus.pop = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_simul();
    test_midreset();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock controller that sequences the dual-port sram as a synchronous FIFO. It owns the write and read pointers, gates write and read enables, and produces full, empty, almost-full, almost-empty and occupancy status. Data does not pass through this block: wrdata goes straight to sram, and rddata comes back from sram alongside this block's rd_valid strobe. Both sram clocks (wrclk, rdclk) are tied to clk at the top level.

Parameters:
FIFO_PTR, 4, pointer width into sram; must match sram FIFO_PTR
FIFO_DEPTH, 16, number of entries; must equal 2**FIFO_PTR
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL

Ports:
clk  input  1  single clock for controller and sram; all logic on the rising edge
rst  input  1  synchronous reset, active-high
push  input  1  write request; data is presented on sram wrdata in the same cycle
pop  input  1  read request
wren  output  1  to sram wren; equals push & ~full & ~rst
wrptr  output  FIFO_PTR  to sram wrptr; low bits of the write pointer
rden  output  1  to sram rden; equals pop & ~empty & ~rst
rdptr  output  FIFO_PTR  to sram rdptr; low bits of the read pointer
rd_valid  output  1  sram rddata is valid this cycle
full  output  1  count == FIFO_DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  FIFO_PTR+1  current occupancy, 0..FIFO_DEPTH

Behaviour:
- Internal state:
  - wr_ptr and rd_ptr are FIFO_PTR+1 bits wide; the MSB is the wrap bit.
  - count register is FIFO_PTR+1 bits wide.
  - rd_valid register.
- Reset (rst=1 at a clock edge):
  - wr_ptr, rd_ptr, count and rd_valid go to 0.
  - Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=0.
  - wren and rden are forced to 0 combinationally while rst=1, so a reset mid-operation never writes or reads sram.
  - sram contents are not cleared; stale data is unreachable because the pointers are equal.
- Accept rules, evaluated on state registered before the edge:
  - wr_acc = push & ~full.
  - rd_acc = pop & ~empty.
  - A push while full is dropped: no pointer change, no sram write.
  - A pop while empty is dropped: rd_valid is 0 in the next cycle.
- Pointer update:
  - wr_acc: wr_ptr += 1.
  - rd_acc: rd_ptr += 1.
  - Pointers wrap naturally modulo 2**(FIFO_PTR+1); wrptr and rdptr wrap from FIFO_DEPTH-1 to 0.
- Count update:
  - wr_acc only: +1.
  - rd_acc only: -1.
  - Both or neither: unchanged.
- Simultaneous push and pop:
  - When full: only the pop is accepted; count goes to FIFO_DEPTH-1. The push must be retried.
  - When empty: only the push is accepted; count goes to 1. No read-through of the word being written.
  - Otherwise: both are accepted, count is unchanged, and sram writes and reads different addresses.
- Read latency:
  - sram read is registered, so rddata for an accepted pop is valid exactly 1 cycle later.
  - rd_valid is a register loaded with rd_acc each cycle, aligned to sram rddata.
  - Back-to-back pops give rd_valid high on consecutive cycles.
- Status flags:
  - All flags decode combinationally from the registered count.
  - Flags change 1 cycle after the push or pop edge.
- Consistency invariants, which the bench must assert:
  - count == wr_ptr - rd_ptr (mod 2**(FIFO_PTR+1)).
  - full iff the pointers' low bits are equal and their MSBs differ.

Optional Feature:
Macro SYNC_FIFO_ERR_EN.
- Defined:
  - Adds output ports overflow (1) and underflow (1).
  - overflow is sticky and sets on the edge after push & full.
  - underflow is sticky and sets on the edge after pop & empty.
  - Both clear only on rst.
- Undefined:
  - Ports and logic are absent.
  - Dropped requests are silent.
  - All other behaviour is identical.

Test Plan:
- Reset, then idle 3 cycles -> count=0, empty=1, almost_empty=1, full=0, wren=0, rden=0, rd_valid=0.
- 16 consecutive pushes of data 0x100+i -> wrptr walks 0..15 and wraps to 0; after the 16th edge full=1, count=16; almost_full first goes high after the 12th push; a 17th push gives wren=0 and count stays 16 (overflow=1 if SYNC_FIFO_ERR_EN).
- From full, 16 consecutive pops -> rd_valid high on cycles 1..16 after the first pop; rddata is 0x100..0x10F in order; empty=1 after the last pop; a 17th pop gives rden=0 and rd_valid=0 the next cycle (underflow=1 if SYNC_FIFO_ERR_EN).
- Fill to 8, then 20 cycles of simultaneous push+pop -> count stays 8, pointers wrap past 15, and read data order matches write order with no loss.
- Simultaneous push+pop at full -> count 16 goes to 15, no sram write. Simultaneous push+pop at empty -> count 0 goes to 1, rd_valid stays 0.
- Assert rst mid-stream with count=5 and push=pop=1 -> in that cycle wren=rden=0; next cycle count=0, empty=1, rd_valid=0, error flags cleared.
